// File: rtl/link_pkg.sv
// -----------------------------------------------------------------------------
// link_pkg
// Definitions shared by the initiator and receiver ends of the 4-phase req/ack
// byte link: handshake state encoding, byte width and the default ack timeout.
// -----------------------------------------------------------------------------
package link_pkg;

  // Both link ends move bytes of this width.
  localparam int unsigned BYTE_W = 8;

  // Cycles the initiator waits for an ack edge before it abandons a byte.
  // Used only when LINK_MASTER_ACK_TIMEOUT_EN is defined.
  localparam int unsigned DEFAULT_TIMEOUT = 15;

  typedef logic [BYTE_W-1:0] link_byte_t;

  // Initiator handshake states.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,  // no transfer in progress
    REQ_HI    = 2'd1,  // req high, waiting for ack to rise
    WAIT_ACK0 = 2'd2,  // req low, waiting for ack to fall
    GAP       = 2'd3   // one guaranteed req-low cycle before the next byte
  } link_state_e;

endpackage : link_pkg

// File: rtl/link_byte_fifo.sv
// -----------------------------------------------------------------------------
// link_byte_fifo
// Synchronous byte FIFO that buffers producer data ahead of the link.
// The head entry is visible combinationally on 'head' whenever 'empty' is low.
//
// Parameters:
//   DEPTH  number of entries (power of two, >= 2)
//
// Ports:
//   clk    clock, rising edge
//   rst    asynchronous active-low reset; empties the FIFO
//   push   write 'din' (accepted when not full, or when full with a pop)
//   din    byte to write
//   pop    discard the head entry (ignored when empty)
//   head   oldest buffered byte
//   full   all DEPTH entries occupied
//   empty  no entries occupied
// -----------------------------------------------------------------------------
module link_byte_fifo
  import link_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  link_byte_t din,
  input  logic       pop,
  output link_byte_t head,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // One extra pointer bit separates "full" from "empty" when the index bits
  // are equal; the pointers simply wrap through 2*DEPTH values.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  link_byte_t  mem [DEPTH];

  logic do_push;
  logic do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees the slot in the same cycle, so a push is still legal when full.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign head = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      // NOTE: sequential state is always updated with non-blocking assignments
      // so every register samples pre-edge values regardless of statement order.
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // define which entries are valid, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule : link_byte_fifo

// File: rtl/link_master_fsm.sv
// -----------------------------------------------------------------------------
// link_master_fsm
// Initiator end of the 4-phase req/ack byte link. Bytes from a valid/ready
// producer are buffered in link_byte_fifo and each one is sent with a full
// handshake (req rise, ack rise, req fall, ack fall) before the next starts.
// The receiver captures data_out on the rising edge of req.
//
// Configuration macro:
//   LINK_MASTER_ACK_TIMEOUT_EN  enables the ack watchdog: a byte whose ack edge
//                               does not arrive within TIMEOUT cycles is
//                               abandoned and timeout_err is set (sticky).
//                               Without it the handshake waits indefinitely.
//
// Parameters:
//   FIFO_DEPTH  upstream buffer entries (power of two, >= 2)
//   CNT_W       width of the completed-transfer counter
//   TIMEOUT     ack watchdog limit in cycles (watchdog build only)
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-low reset; drops req at once
//   in_valid     upstream byte valid
//   in_data      upstream byte
//   in_ready     buffer not full
//   ack          receiver acknowledge (already synchronous to clk)
//   req          link request
//   data_out     link data, stable while req is high, holds the last byte sent
//   busy         handshake in progress (state other than IDLE)
//   byte_done    one-cycle pulse per completed transfer
//   tx_count     completed transfers, wraps at 2^CNT_W
//   timeout_err  sticky abort flag (constant 0 without the watchdog)
// -----------------------------------------------------------------------------
module link_master_fsm
  import link_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  input  logic              ack,
  output logic              req,
  output logic [BYTE_W-1:0] data_out,
  output logic              busy,
  output logic              byte_done,
  output logic [CNT_W-1:0]  tx_count,
  output logic              timeout_err
);

  // ---------------------------------------------------------------------------
  // Upstream buffer
  // ---------------------------------------------------------------------------
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_pop;
  link_byte_t fifo_head;

  assign in_ready = !fifo_full;

  link_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid && in_ready),
    .din   (in_data),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Handshake state and registered link outputs
  // ---------------------------------------------------------------------------
  link_state_e      state_q,  state_d;
  logic             req_q,    req_d;
  link_byte_t       data_q,   data_d;
  logic             done_q,   done_d;
  logic [CNT_W-1:0] count_q,  count_d;

`ifdef LINK_MASTER_ACK_TIMEOUT_EN
  // The timer holds "cycles already spent in this state"; the abort fires on
  // the edge that would end the TIMEOUT-th cycle.
  localparam int unsigned   TMR_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  logic [TMR_W-1:0] timer_q, timer_d;
  logic             err_q,   err_d;
`endif

  // NOTE: combinational logic uses blocking assignments and gives every output
  // a default before the case statement, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    data_d   = data_q;
    done_d   = 1'b0;
    count_d  = count_q;
    fifo_pop = 1'b0;

    case (state_q)
      IDLE: begin
        // The byte must already sit at the FIFO head, so req rises one cycle
        // after the byte becomes visible there.
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          data_d   = fifo_head;
          req_d    = 1'b1;
          state_d  = REQ_HI;
        end
      end
      REQ_HI: begin
        // The first ack=1 sampled here counts, including one that was already
        // high on entry.
        if (ack) begin
          req_d   = 1'b0;
          state_d = WAIT_ACK0;
        end
      end
      WAIT_ACK0: begin
        if (!ack) begin
          done_d  = 1'b1;
          count_d = count_q + CNT_W'(1);
          state_d = GAP;
        end
      end
      GAP: begin
        // Guarantees the receiver a req-low cycle before the next rising edge.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef LINK_MASTER_ACK_TIMEOUT_EN
    timer_d = '0;
    err_d   = err_q;
    if ((state_q == REQ_HI || state_q == WAIT_ACK0) && (state_d == state_q)) begin
      if (timer_q == TMR_LAST) begin
        // Abandon the byte: no byte_done, no count, straight to the gap.
        req_d   = 1'b0;
        err_d   = 1'b1;
        state_d = GAP;
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      count_q <= '0;
`ifdef LINK_MASTER_ACK_TIMEOUT_EN
      timer_q <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      count_q <= count_d;
`ifdef LINK_MASTER_ACK_TIMEOUT_EN
      timer_q <= timer_d;
      err_q   <= err_d;
`endif
    end
  end

  assign req       = req_q;
  assign data_out  = data_q;
  assign byte_done = done_q;
  assign tx_count  = count_q;
  assign busy      = (state_q != IDLE);

`ifdef LINK_MASTER_ACK_TIMEOUT_EN
  assign timeout_err = err_q;
`else
  // No watchdog: the flag is 0 for every legal TIMEOUT; a zero TIMEOUT is an
  // unusable configuration and shows up as a permanently raised flag.
  assign timeout_err = (TIMEOUT == 0);
`endif

endmodule : link_master_fsm

// File: tb/tb_link_master_fsm.sv
// -----------------------------------------------------------------------------
// tb_link_master_fsm
// Self-checking bench for link_master_fsm. A producer queue and a receiver
// drive the DUT; a transaction-level model of the link protocol predicts every
// output cycle by cycle, and the bytes the receiver captures on req rising
// edges are compared against the bytes the producer handed over.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_link_master_fsm;
  import link_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int TMO   = 15;
  localparam int WRAP  = 1 << CNT_W;
`ifdef LINK_MASTER_ACK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [BYTE_W-1:0] in_data = '0;
  logic              in_ready;
  logic              ack = 1'b0;
  logic              req;
  logic [BYTE_W-1:0] data_out;
  logic              busy;
  logic              byte_done;
  logic [CNT_W-1:0]  tx_count;
  logic              timeout_err;

  always #5 clk = ~clk;

  link_master_fsm #(
    .FIFO_DEPTH (DEPTH),
    .CNT_W      (CNT_W),
    .TIMEOUT    (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .ack         (ack),
    .req         (req),
    .data_out    (data_out),
    .busy        (busy),
    .byte_done   (byte_done),
    .tx_count    (tx_count),
    .timeout_err (timeout_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  // ---------------- protocol model ----------------
  logic [7:0] q[$];          // bytes accepted but not yet sent
  logic [7:0] flight = '0;   // byte most recently launched
  bit  m_req, m_wait, m_gap, m_err;
  int  m_run;                // cycles already spent in the current handshake phase
  int  completed;            // completed transfers since reset

  // ---------------- producer / receiver ----------------
  logic [7:0] to_send[$];
  logic [7:0] sent_log[$];
  logic [7:0] rx_log[$];
  int  valid_pct = 100;
  bit  rx_hold_low = 1'b0;
  bit  rx_rand = 1'b0;
  int  rx_wait = 0;
  int  rx_hold = 0;

  // ---------------- DUT observations ----------------
  bit  prev_dut_req = 1'b0;
  bit  seen_rise = 1'b0;
  int  dut_low_run = 0;
  int  done_pulses = 0;
  bit  ready_dropped = 1'b0;

  function automatic void model_reset();
    q.delete();
    flight = '0;
    m_req = 0; m_wait = 0; m_gap = 0; m_err = 0;
    m_run = 0;
    completed = 0;
    seen_rise = 0;
    prev_dut_req = 0;
    dut_low_run = 0;
  endfunction

  // One clock: the inputs currently driven are applied at the next rising
  // edge, outputs are checked at the following falling edge, then new inputs
  // are driven.
  task automatic cycle();
    bit         ack_e, push_e;
    logic [7:0] din_e;
    bit         n_req, n_wait, n_gap, n_done;
    ack_e  = ack;
    push_e = in_valid && (q.size() < DEPTH);
    din_e  = in_data;
    n_req = 0; n_wait = 0; n_gap = 0; n_done = 0;
    @(negedge clk);

    if (!rst) begin
      model_reset();
    end else begin
      if (m_req) begin
        if (ack_e) begin
          n_wait = 1; m_run = 0;
        end else if (TO_EN && m_run >= TMO - 1) begin
          n_gap = 1; m_err = 1;
        end else begin
          n_req = 1; m_run++;
        end
      end else if (m_wait) begin
        if (!ack_e) begin
          n_gap = 1; n_done = 1; completed++;
        end else if (TO_EN && m_run >= TMO - 1) begin
          n_gap = 1; m_err = 1;
        end else begin
          n_wait = 1; m_run++;
        end
      end else if (!m_gap && q.size() > 0) begin
        n_req = 1; m_run = 0;
        flight = q.pop_front();
      end
      if (push_e) begin
        q.push_back(din_e);
        sent_log.push_back(din_e);
        void'(to_send.pop_front());
      end
    end

    check("req",         req,         n_req);
    check("data_out",    data_out,    flight);
    check("byte_done",   byte_done,   n_done);
    check("tx_count",    tx_count,    completed % WRAP);
    check("busy",        busy,        n_req | n_wait | n_gap);
    check("in_ready",    in_ready,    q.size() < DEPTH);
    check("timeout_err", timeout_err, m_err);

    if (req && !prev_dut_req) begin
      rx_log.push_back(data_out);
      if (seen_rise) check("req_low_gap", dut_low_run >= 2, 1);
      seen_rise   = 1;
      dut_low_run = 0;
    end
    if (!req) dut_low_run++;
    prev_dut_req = req;
    if (byte_done) done_pulses++;
    if (!in_ready) ready_dropped = 1;
    m_req = n_req; m_wait = n_wait; m_gap = n_gap;

    // Receiver: raise ack after a delay once req is seen, hold it, and drop it
    // once req has fallen.
    if (rx_hold_low) begin
      ack = 1'b0;
    end else if (!ack) begin
      if (req) begin
        if (rx_wait == 0) begin
          ack = 1'b1;
          rx_hold = rx_rand ? int'($urandom_range(0, 3)) : 1;
        end else begin
          rx_wait--;
        end
      end else begin
        rx_wait = rx_rand ? int'($urandom_range(0, 3)) : 0;
      end
    end else if (rx_hold > 0) begin
      rx_hold--;
    end else if (!req) begin
      ack = 1'b0;
    end

    // Producer
    if (rst && to_send.size() > 0 && int'($urandom_range(0, 99)) < valid_pct) begin
      in_valid = 1'b1;
      in_data  = to_send[0];
    end else begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
  endtask

  task automatic run_idle(input string tag, input int limit);
    bit idle;
    idle = 0;
    for (int i = 0; i < limit && !idle; i++) begin
      cycle();
      idle = (to_send.size() == 0) && (q.size() == 0) && !m_req && !m_wait && !m_gap && !ack;
    end
    check({tag, "_drain"}, idle, 1);
  endtask

  task automatic compare_logs(input string tag);
    check({tag, "_byte_count"}, rx_log.size(), sent_log.size());
    for (int i = 0; i < rx_log.size() && i < sent_log.size(); i++)
      check({tag, "_byte"}, rx_log[i], sent_log[i]);
    rx_log.delete();
    sent_log.delete();
  endtask

  task automatic async_reset_mid();
    #2 rst = 1'b0;
    #1 check("async_req_drop", req, 0);
    check("async_busy", busy, 0);
    to_send.delete();
    in_valid = 1'b0;
    ack = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    rx_log.delete();
    sent_log.delete();
  endtask

  initial begin
    model_reset();
    // Power-on reset
    for (int i = 0; i < 3; i++) cycle();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) cycle();

    // Single byte, receiver acks one cycle after req and holds two cycles
    rx_rand = 0;
    done_pulses = 0;
    to_send.push_back(8'hA5);
    run_idle("single", 40);
    check("single_tx_count", tx_count, 1);
    check("single_pulses", done_pulses, 1);
    check("single_busy", busy, 0);
    compare_logs("single");

    // Back-to-back bytes on consecutive cycles
    ready_dropped = 0;
    for (int b = 1; b <= 4; b++) to_send.push_back(8'(b));
    run_idle("b2b", 80);
    check("b2b_tx_count", tx_count, 5);
    check("b2b_ready_dropped", ready_dropped, 0);
    compare_logs("b2b");

    // Fill the buffer while the receiver withholds ack
    rx_hold_low = 1;
    for (int b = 0; b < 6; b++) to_send.push_back(8'hC0 + 8'(b));
    for (int i = 0; i < 8; i++) cycle();
    check("full_in_ready", in_ready, 0);
    check("full_req_held", req, 1);
    rx_hold_low = 0;
    run_idle("full", 120);
    check("full_tx_count", tx_count, 11);
    compare_logs("full");

    // Reset while req is high
    rx_hold_low = 1;
    to_send.push_back(8'h77);
    for (int i = 0; i < 10 && !req; i++) cycle();
    check("rst_reach_req", req, 1);
    async_reset_mid();
    rx_hold_low = 0;
    for (int i = 0; i < 3; i++) cycle();
    check("rst_tx_count", tx_count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);

    // 17 transfers with a 4-bit counter
    rx_rand = 1;
    for (int b = 0; b < 17; b++) to_send.push_back(8'($urandom));
    run_idle("wrap", 600);
    check("wrap_tx_count", tx_count, 1);
    compare_logs("wrap");

    // Randomized traffic and receiver timing
    valid_pct = 60;
    for (int b = 0; b < 150; b++) to_send.push_back(8'($urandom));
    run_idle("rand", 4000);
    check("rand_tx_count", tx_count, (17 + 150) % WRAP);
    compare_logs("rand");
    valid_pct = 100;

`ifdef LINK_MASTER_ACK_TIMEOUT_EN
    begin
      int base;
      base = completed;
      rx_hold_low = 1;
      to_send.push_back(8'h5A);
      for (int i = 0; i < 25; i++) cycle();
      check("tmo_err", timeout_err, 1);
      check("tmo_tx_count", tx_count, base % WRAP);
      rx_hold_low = 0;
      to_send.push_back(8'h33);
      run_idle("tmo_next", 60);
      check("tmo_next_tx_count", tx_count, (base + 1) % WRAP);
      compare_logs("tmo");
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_link_master_fsm
